subtractor_16bit_seq: RTL and testbench

Multi-cycle 16-bit subtractor, the inverse arithmetic partner of the combinational adder_16bit. It computes a - b - bin two bits per clock, LSB first, and returns diff, bout (unsigned borrow) and overflow (signed).
It has valid/ready handshakes on both sides, so it can sit between pipeline stages that need a low-area subtract path.

---
 rtl/subtractor_16bit_seq_if.sv | 26 ++
 rtl/subtractor_16bit_seq.sv | 116 +++++++++++
 tb/tb_subtractor_16bit_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/subtractor_16bit_seq_if.sv
// Operand/result handshake bundle for the sequential subtractor.
// master drives operands and result acceptance; slave is the subtractor.
interface subtractor_16bit_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, overflow
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, overflow
  );
endinterface

// File: rtl/subtractor_16bit_seq.sv
// Multi-cycle a - b - bin, BITS_PER_CYCLE bits per clock, LSB chunk first.
// Optional macro SUB_SATURATE_EN clamps diff to the signed limit on overflow.
module subtractor_16bit_seq #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  subtractor_16bit_seq_if.slave bus
);
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int B     = BITS_PER_CYCLE;

  generate
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] diff_sh_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic             borrow_reg;
  logic             bout_reg;
  logic             overflow_reg;
  logic [CW-1:0]    count_reg;

  // Top bit of the (B+1)-bit difference is the chunk's borrow out.
  logic [B:0]       chunk_next;
  logic [WIDTH-1:0] diff_full_next;
  logic [WIDTH-1:0] diff_out_next;
  logic             overflow_next;

  assign chunk_next = {1'b0, a_sh_reg[B-1:0]} - {1'b0, b_sh_reg[B-1:0]}
                    - {{B{1'b0}}, borrow_reg};

  generate
    if (B == WIDTH) begin : g_one_chunk
      assign diff_full_next = chunk_next[B-1:0];
    end else begin : g_multi_chunk
      assign diff_full_next = {chunk_next[B-1:0], diff_sh_reg[WIDTH-1:B]};
    end
  endgenerate

  assign overflow_next = (a_msb_reg != b_msb_reg) && (diff_full_next[WIDTH-1] != a_msb_reg);

`ifdef SUB_SATURATE_EN
  assign diff_out_next = !overflow_next ? diff_full_next
                       : (a_msb_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign diff_out_next = diff_full_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      diff_sh_reg  <= '0;
      diff_reg     <= '0;
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
      borrow_reg   <= 1'b0;
      bout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_reg   <= bus.a;
            b_sh_reg   <= bus.b;
            a_msb_reg  <= bus.a[WIDTH-1];
            b_msb_reg  <= bus.b[WIDTH-1];
            borrow_reg <= bus.bin;
            count_reg  <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          a_sh_reg    <= a_sh_reg >> B;
          b_sh_reg    <= b_sh_reg >> B;
          diff_sh_reg <= diff_full_next;
          borrow_reg  <= chunk_next[B];
          count_reg   <= count_reg + 1'b1;
          // Results become visible only on the DONE entry edge.
          if (count_reg == CW'(STEPS - 1)) begin
            diff_reg     <= diff_out_next;
            bout_reg     <= chunk_next[B];
            overflow_reg <= overflow_next;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_subtractor_16bit_seq.sv
// Scoreboard bench for subtractor_16bit_seq: directed cases plus random stream
// checked against an integer-arithmetic reference of a - b - bin.
module tb_subtractor_16bit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  subtractor_16bit_seq_if #(.WIDTH(16)) bus ();

  subtractor_16bit_seq #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int checks  = 0;
  int passes  = 0;
  int pushed  = 0;
  int popped  = 0;
  int flushed = 0;

  function automatic res_t ref_model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int   u;
    int   s;
    res_t r;
    u = int'(a) - int'(b) - int'(bin);
    s = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r.diff = u[15:0];
    r.bout = (u < 0);
    r.ovf  = (s > 32767) || (s < -32768);
`ifdef SUB_SATURATE_EN
    if (r.ovf) r.diff = (s > 32767) ? 16'h7FFF : 16'h8000;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Accept watcher: the edge following this negedge captures the operands.
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(ref_model(bus.a, bus.b, bus.bin));
      pushed++;
    end
  end

  // Result monitor: the edge following this negedge completes the handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        popped++;
        $display("result %0d: diff=%04h bout=%0b ovf=%0b (exp %04h %0b %0b)",
                 popped, bus.diff, bus.bout, bus.overflow, e.diff, e.bout, e.ovf);
        chk("sb_diff", 32'(bus.diff), 32'(e.diff));
        chk("sb_bout", 32'(bus.bout), 32'(e.bout));
        chk("sb_ovf",  32'(bus.overflow), 32'(e.ovf));
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [15:0] ed, input logic eb, input logic eo, input string tag);
    int n;
    bit ok;
    bit rdy_bad;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    rdy_bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.in_ready) rdy_bad = 1'b1;
      if (bus.out_valid) begin n = i; break; end
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_in_ready_low"}, 32'(rdy_bad), 32'd0);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
    chk({tag, "_ovf"},  32'(bus.overflow), 32'(eo));
    if (bus.out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_release"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] snap_d;
    logic        snap_b;
    logic        snap_o;
    bit          ok;
    int          target;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_flags", 32'({bus.bout, bus.overflow}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(16'h5678, 16'h1234, 1'b0, 16'h4444, 1'b0, 1'b0, "basic");
    do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "under");
    do_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, "bin_only");
`ifdef SUB_SATURATE_EN
    do_op(16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_neg");
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, "ovf_pos");
`else
    do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "ovf_neg");
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "ovf_pos");
`endif

    // Backpressure: result must hold while consumer stalls and inputs churn.
    bus.out_ready = 1'b0;
    do_op(16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0, "bp");
    snap_d = bus.diff; snap_b = bus.bout; snap_o = bus.overflow;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = ~bus.in_valid; bus.a = 16'($urandom); bus.b = 16'($urandom);
      @(negedge clk);
      if (bus.diff !== snap_d || bus.bout !== snap_b || bus.overflow !== snap_o ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
    end
    chk("bp_hold", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    do_op(16'hABCD, 16'h0BCD, 1'b0, 16'hA000, 1'b0, 1'b0, "bp_next");

    // Asynchronous reset three cycles into RUN.
    @(posedge clk); #1;
    bus.a = 16'h1111; bus.b = 16'h2222; bus.bin = 1'b0; bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    chk("ar_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ar_diff", 32'(bus.diff), 32'd0);
    chk("ar_ctl", 32'({bus.out_valid, bus.in_ready, bus.bout, bus.overflow}), 32'd0);
    flushed += exp_q.size();
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "ar_next");

    // Random stream with in_valid held and random consumer stalls.
    target = pushed + 200;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 20000 && pushed < target; cyc++) begin
      @(posedge clk); #1;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    chk("rand_issued", 32'(pushed >= target), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("no_drop_dup", 32'(popped), 32'(pushed - flushed));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
